// File: rtl/simd_alu_issue_queue_pkg.sv
// Shared SIMD ALU widths used by the issue queue and its buffers.
// Opcode encodings belong to the ALU itself and are deliberately not defined here.
package simd_alu_issue_queue_pkg;

  localparam int SIMD_DATA_WIDTH = 256;
  localparam int SIMD_OPC_WIDTH  = 5;

  // The ALU has a fixed one-cycle latency, so two result slots cover one
  // in-flight op plus one result waiting on the consumer.
  localparam int RBUF_DEPTH = 2;

endpackage

// File: rtl/simd_alu_sync_fifo.sv
// Single-clock FIFO with wrapping pointers and an explicit occupancy counter.
// A push into a full FIFO or a pop from an empty one is ignored.
module simd_alu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: non-blocking assignments for every register so all flops sample
  // the same pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; stale entries are unreachable because the
  // counter gates every read, and consumers mask the head when empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/simd_alu_issue_queue.sv
// Command FIFO, credit-based issue and result buffer around a one-cycle ALU
// that has no stall input; results return in acceptance order.
module simd_alu_issue_queue
  import simd_alu_issue_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = SIMD_DATA_WIDTH,
  parameter int OPC_W  = SIMD_OPC_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_W-1:0]          s_a,
  input  logic [DATA_W-1:0]          s_b,
  input  logic [OPC_W-1:0]           s_opcode,
  output logic [DATA_W-1:0]          alu_in_a,
  output logic [DATA_W-1:0]          alu_in_b,
  output logic [OPC_W-1:0]           alu_opcode,
  input  logic [DATA_W-1:0]          alu_out,
  input  logic [DATA_W/8-1:0]        alu_ovf,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_W-1:0]          m_data,
  output logic [DATA_W/8-1:0]        m_ovf,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int CMD_W = 2*DATA_W + OPC_W;
  localparam int RES_W = DATA_W + DATA_W/8;
  localparam int RCW   = $clog2(RBUF_DEPTH) + 1;

  logic [CMD_W-1:0] cmd_head;
  logic             cmd_full;
  logic             cmd_empty;
  logic [RES_W-1:0] res_head;
  logic             res_empty;
  logic             unused_res_full;
  logic [RCW-1:0]   rbuf_count;
  logic             inflight;
  logic             issue;
  logic             m_pop;
  logic [RCW:0]     credit_used;

  assign s_ready = !cmd_full;
  assign m_valid = !res_empty;
  assign m_pop   = m_valid && m_ready;

  // Slots committed to the result buffer once this cycle's pop retires.
  assign credit_used = (RCW+1)'(inflight) + (RCW+1)'(rbuf_count) - (RCW+1)'(m_pop);
  assign issue       = !cmd_empty && (credit_used < (RCW+1)'(RBUF_DEPTH));

  // Zeros when idle; the ALU result from them is discarded since inflight is 0.
  assign {alu_opcode, alu_in_b, alu_in_a} = issue ? cmd_head : '0;

  assign {m_ovf, m_data} = m_valid ? res_head : '0;

  simd_alu_sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s_valid),
    .pop   (issue),
    .din   ({s_opcode, s_b, s_a}),
    .dout  (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (fifo_count)
  );

  simd_alu_sync_fifo #(
    .WIDTH (RES_W),
    .DEPTH (RBUF_DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .pop   (m_pop),
    .din   ({alu_ovf, alu_out}),
    .dout  (res_head),
    .full  (unused_res_full),
    .empty (res_empty),
    .count (rbuf_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= issue;
  end

endmodule

// File: tb/tb_simd_alu_issue_queue.sv
// Bench for simd_alu_issue_queue with a one-cycle ALU stand-in and an
// in-order scoreboard fed from accepted commands.
module tb_simd_alu_issue_queue;
  import simd_alu_issue_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int DW    = SIMD_DATA_WIDTH;
  localparam int OW    = SIMD_OPC_WIDTH;
  localparam int VW    = DW/8;
  localparam int CW    = $clog2(DEPTH) + 1;

  // Stand-in ALU encodings, local to the bench.
  localparam logic [OW-1:0] OP_ADD8  = 5'd1;
  localparam logic [OW-1:0] OP_ADD32 = 5'd2;
  localparam logic [OW-1:0] OP_ADD64 = 5'd3;
  localparam logic [OW-1:0] OP_SUB32 = 5'd4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_a = '0;
  logic [DW-1:0] s_b = '0;
  logic [OW-1:0] s_opcode = '0;
  logic [DW-1:0] alu_in_a, alu_in_b, alu_out;
  logic [OW-1:0] alu_opcode;
  logic [VW-1:0] alu_ovf;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [VW-1:0] m_ovf;
  logic [CW-1:0] fifo_count;

  int vectors = 0;
  int misc    = 0;
  int n_acc   = 0;
  int n_del   = 0;
  logic [DW+VW-1:0] sbq[$];
  logic [DW+VW-1:0] sb_exp;

  always #5 clk = ~clk;

  simd_alu_issue_queue #(.DEPTH(DEPTH), .DATA_W(DW), .OPC_W(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_opcode(s_opcode),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_ovf(alu_ovf),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_ovf(m_ovf),
    .fifo_count(fifo_count)
  );

  // Lane-wise add/sub with per-byte signed-overflow flags over each lane.
  function automatic logic [DW+VW-1:0] alu_ref(input logic [OW-1:0] op,
                                               input logic [DW-1:0] a, input logic [DW-1:0] b);
    int lb, w;
    bit sub;
    logic [63:0] x, y, s, mask;
    logic [DW-1:0] r;
    logic [VW-1:0] o;
    sub = 0;
    case (op)
      OP_ADD8:  lb = 1;
      OP_ADD32: lb = 4;
      OP_SUB32: begin lb = 4; sub = 1; end
      default:  lb = 8;
    endcase
    w = 8*lb;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    r = '0;
    o = '0;
    for (int l = 0; l < DW/w; l++) begin
      x = 64'(a >> (l*w)) & mask;
      y = 64'(b >> (l*w)) & mask;
      s = (sub ? x - y : x + y) & mask;
      r |= DW'(s) << (l*w);
      if ((x[w-1] == (sub ? ~y[w-1] : y[w-1])) && (s[w-1] != x[w-1]))
        o |= VW'((1 << lb) - 1) << (l*lb);
    end
    return {o, r};
  endfunction

  // ALU stand-in: registered inputs, combinational result the next cycle.
  logic [DW-1:0] ra, rb;
  logic [OW-1:0] rop;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra <= '0; rb <= '0; rop <= '0;
    end else begin
      ra <= alu_in_a; rb <= alu_in_b; rop <= alu_opcode;
    end
  end
  assign {alu_ovf, alu_out} = alu_ref(rop, ra, rb);

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      misc++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Scoreboard: every accepted command must come back once, in order.
  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
      n_acc = 0;
      n_del = 0;
    end else begin
      if (m_valid && m_ready) begin
        n_del++;
        if (sbq.size() == 0) begin
          vectors++;
          misc++;
          $display("FAIL spurious_result: got %0h, required no result", m_data);
        end else begin
          sb_exp = sbq.pop_front();
          check("sb_data", m_data, sb_exp[DW-1:0]);
          check("sb_ovf", DW'(m_ovf), DW'(sb_exp[DW+VW-1:DW]));
        end
      end
      if (s_valid && s_ready) begin
        sbq.push_back(alu_ref(s_opcode, s_a, s_b));
        n_acc++;
      end
      check("fifo_count_bound", DW'(fifo_count > CW'(DEPTH)), '0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Holds s_valid until accepted; returns at the start of the following cycle.
  task automatic send(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    s_valid = 1'b1; s_opcode = op; s_a = a; s_b = b;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (s_ready) begin
        cyc();
        s_valid = 1'b0;
        return;
      end
      cyc();
    end
    s_valid = 1'b0;
    vectors++;
    misc++;
    $display("FAIL send_timeout: s_ready low for 300 cycles, required high");
  endtask

  // Called in the cycle after acceptance; returns cycles from acceptance to m_valid.
  task automatic wait_m_valid(output int n);
    n = 1;
    while (n < 20) begin
      #1;
      if (m_valid) return;
      cyc();
      n++;
    end
  endtask

  function automatic logic [DW-1:0] rand256();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  typedef struct {
    logic [OW-1:0] op;
    logic [31:0]   a32, b32, exp32;
    logic [3:0]    exp_ovf4;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc, idx;
    logic [15:0] vmask;
    logic [DW-1:0] a, b;
    logic [OW-1:0] op;
    bit seen;
    bit done;

    tbl[0] = '{OP_ADD32, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 4'h0};
    tbl[1] = '{OP_ADD8,  32'h7F7F_7F7F, 32'h0101_0101, 32'h8080_8080, 4'hF};
    tbl[2] = '{OP_ADD32, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'hF};
    tbl[3] = '{OP_SUB32, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 4'h0};
    tbl[4] = '{OP_ADD8,  32'hFFFF_FFFF, 32'h0101_0101, 32'h0000_0000, 4'h0};
    tbl[5] = '{OP_ADD64, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678, 4'h0};
    tbl[6] = '{OP_SUB32, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'hF};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", DW'(s_ready), DW'(1));
    check("rst_m_valid", DW'(m_valid), '0);
    check("rst_m_data", m_data, '0);
    check("rst_m_ovf", DW'(m_ovf), '0);
    check("rst_alu_a", alu_in_a, '0);
    check("rst_alu_b", alu_in_b, '0);
    check("rst_alu_opc", DW'(alu_opcode), '0);
    check("rst_fifo_count", DW'(fifo_count), '0);
    rst_n = 1'b1;
    cyc();

    // Single ops: latency and lane results
    m_ready = 1'b1;
    foreach (tbl[i]) begin
      send(tbl[i].op, {8{tbl[i].a32}}, {8{tbl[i].b32}});
      wait_m_valid(n);
      check($sformatf("tbl%0d_latency", i), DW'(n), DW'(3));
      check($sformatf("tbl%0d_data", i), m_data, {8{tbl[i].exp32}});
      check($sformatf("tbl%0d_ovf", i), DW'(m_ovf), DW'({8{tbl[i].exp_ovf4}}));
      cyc();
      cyc();
    end

    // 8 back-to-back S_ADD8: one accept per cycle, 8 consecutive results
    acc = 0;
    vmask = '0;
    s_opcode = OP_ADD8; s_a = {32{8'h7F}}; s_b = {32{8'h01}};
    for (int i = 0; i < 16; i++) begin
      s_valid = (i < 8);
      #1;
      if (s_valid && s_ready) acc++;
      vmask[i] = m_valid;
      if (m_valid) begin
        check("b2b_data", m_data, {32{8'h80}});
        check("b2b_ovf", DW'(m_ovf), DW'(32'hFFFF_FFFF));
      end
      cyc();
    end
    s_valid = 1'b0;
    check("b2b_accepts", DW'(acc), DW'(8));
    check("b2b_valid_pattern", DW'(vmask), DW'(16'b0000_0111_1111_1000));

    // Back-pressure: 6 accepted with m_ready low, then the rest once released
    m_ready = 1'b0;
    acc = 0;
    idx = 0;
    s_opcode = OP_ADD64; s_b = '0;
    for (int i = 0; i < 20; i++) begin
      s_valid = (idx < 10);
      s_a = DW'(idx);
      #1;
      if (s_valid && s_ready) begin acc++; idx++; end
      cyc();
    end
    s_valid = 1'b0;
    check("bp_accepts", DW'(acc), DW'(6));
    check("bp_fifo_full", DW'(fifo_count), DW'(DEPTH));
    check("bp_s_ready_low", DW'(s_ready), '0);
    check("bp_m_valid_held", DW'(m_valid), DW'(1));
    m_ready = 1'b1;
    while (idx < 10) begin
      send(OP_ADD64, DW'(idx), '0);
      idx++;
    end
    repeat (10) cyc();
    check("bp_delivered", DW'(n_del), DW'(n_acc));

    // Push and pop together at DEPTH-1
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(OP_ADD32, rand256(), rand256());
    repeat (4) cyc();
    check("pp_pre_count", DW'(fifo_count), DW'(DEPTH-1));
    m_ready = 1'b1;
    s_valid = 1'b1; s_opcode = OP_SUB32; s_a = rand256(); s_b = rand256();
    #1;
    check("pp_s_ready", DW'(s_ready), DW'(1));
    cyc();
    s_valid = 1'b0;
    check("pp_post_count", DW'(fifo_count), DW'(DEPTH-1));
    check("pp_post_s_ready", DW'(s_ready), DW'(1));
    repeat (12) cyc();

    // Reset with one op in flight, one result held and one queued
    m_ready = 1'b0;
    send(OP_ADD32, rand256(), rand256());
    send(OP_ADD8, rand256(), rand256());
    s_valid = 1'b1; s_opcode = OP_ADD64; s_a = rand256(); s_b = rand256();
    cyc();
    s_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_m_valid", DW'(m_valid), '0);
    check("mid_rst_fifo_count", DW'(fifo_count), '0);
    check("mid_rst_s_ready", DW'(s_ready), DW'(1));
    check("mid_rst_m_data", m_data, '0);
    repeat (2) cyc();
    rst_n = 1'b1;
    m_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (m_valid) seen = 1;
      cyc();
    end
    check("post_rst_no_stale", DW'(seen), '0);
    send(OP_ADD32, {8{32'd10}}, {8{32'd20}});
    wait_m_valid(n);
    check("post_rst_latency", DW'(n), DW'(3));
    check("post_rst_data", m_data, {8{32'd30}});
    cyc();

    // Random stream with random back-pressure
    done = 0;
    fork
      begin
        for (int i = 0; i < 160; i++) begin
          a = rand256();
          a[31:0] = i;
          if (i < 60) begin
            op = OP_ADD64;
            b = '0;
          end else begin
            case ($urandom_range(0, 3))
              0: op = OP_ADD8;
              1: op = OP_ADD32;
              2: op = OP_ADD64;
              default: op = OP_SUB32;
            endcase
            b = rand256();
          end
          send(op, a, b);
          if ($urandom_range(0, 3) == 0) cyc();
        end
        done = 1;
      end
      begin
        while (!done) begin
          m_ready = ($urandom_range(0, 1) == 1);
          cyc();
        end
      end
    join
    m_ready = 1'b1;
    repeat (20) cyc();
    check("rand_drained", DW'(sbq.size()), '0);
    check("rand_delivered", DW'(n_del), DW'(n_acc));
    check("rand_final_count", DW'(fifo_count), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
